// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU scheduler: opcodes, FSM encoding, error bits
// and opcode classification helpers.
package alu_pkg;

  localparam int ALU_W = 16;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1000;
  localparam logic [3:0] OP_MOD = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;

  localparam int ERR_DIV0 = 0;
  localparam int ERR_ILL  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic is_slow(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_MUL, OP_DIV, OP_NOT, OP_MOD, OP_LDI: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Request, response and ALU-side signals of the scheduler; the slave modport is
// the scheduler itself, the master modport is everything around it.
interface alu_sched_if;
  import alu_pkg::*;

  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [3:0]        req0_op, req1_op;
  logic [ALU_W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [ALU_W-1:0]  alu_a, alu_b;
  logic [3:0]        alu_ctrl;
  logic [ALU_W-1:0]  alu_result;
  logic              rsp_valid, rsp_ready, rsp_id;
  logic [ALU_W-1:0]  rsp_result;
  logic [1:0]        rsp_err;

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op,
           req0_a, req0_b, req1_a, req1_b, alu_result, rsp_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_ctrl,
           rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op,
           req0_a, req0_b, req1_a, req1_b, alu_result, rsp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_ctrl,
           rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_sched_rr_arb2.sv
// Two-requester round-robin arbiter; the last-grant pointer moves only when
// the caller signals that the grant was actually taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last;

  // last=1 means port 1 won most recently, so port 0 wins the next tie
  always_comb begin
    gnt[0] = req[0] & (~req[1] | last);
    gnt[1] = req[1] & (~req[0] | ~last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last <= 1'b1;
    else if (accept) last <= gnt[1];
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one external combinational ALU between two requesters, holding the
// ALU inputs for MC_CYCLES on slow ops and returning one tagged response each.
//
// state | meaning
// IDLE  | waiting for a request; granted port sees ready
// EXEC  | first ALU cycle; fast ops capture their result here
// WAIT  | remaining MC_CYCLES-1 cycles of a slow op
// RESP  | response presented until rsp_ready
module alu_sched
  import alu_pkg::*;
#(
  parameter int MC_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  alu_sched_if.slave  bus
);

  localparam logic [3:0] MC_LAST = 4'(MC_CYCLES - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              id_q;
  logic [1:0]        gnt;
  logic              accept;
  logic              div0;
  logic [ALU_W-1:0]  res_nxt;
  logic [1:0]        err_nxt;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({bus.req1_valid, bus.req0_valid}),
    .accept (accept),
    .gnt    (gnt)
  );

  assign bus.req0_ready = (state == ST_IDLE) & ~rst & gnt[0];
  assign bus.req1_ready = (state == ST_IDLE) & ~rst & gnt[1];
  assign accept         = bus.req0_ready | bus.req1_ready;

  // divide-by-zero and illegal opcodes never trust the external ALU output
  always_comb begin
    div0    = ((bus.alu_ctrl == OP_DIV) || (bus.alu_ctrl == OP_MOD)) && (bus.alu_b == '0);
    res_nxt = bus.alu_result;
    err_nxt = 2'b00;
    if (!is_legal(bus.alu_ctrl)) begin
      res_nxt          = '0;
      err_nxt[ERR_ILL] = 1'b1;
    end else if (div0) begin
      res_nxt           = (bus.alu_ctrl == OP_DIV) ? '1 : bus.alu_a;
      err_nxt[ERR_DIV0] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      id_q           <= 1'b0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_ctrl   <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_err    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            bus.alu_a    <= gnt[1] ? bus.req1_a  : bus.req0_a;
            bus.alu_b    <= gnt[1] ? bus.req1_b  : bus.req0_b;
            bus.alu_ctrl <= gnt[1] ? bus.req1_op : bus.req0_op;
            id_q         <= gnt[1];
            state        <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!is_slow(bus.alu_ctrl) || (MC_CYCLES == 1)) begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_id     <= id_q;
            bus.rsp_result <= res_nxt;
            bus.rsp_err    <= err_nxt;
            state          <= ST_RESP;
          end else begin
            cnt   <= MC_LAST;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd1) begin
            cnt            <= '0;
            bus.rsp_valid  <= 1'b1;
            bus.rsp_id     <= id_q;
            bus.rsp_result <= res_nxt;
            bus.rsp_err    <= err_nxt;
            state          <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: directed requests push expected responses,
// an independent monitor checks latency, payload and handshake behaviour.
module tb_alu_sched;
  import alu_pkg::*;

  localparam int MC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_sched_if bus();

  alu_sched #(.MC_CYCLES(MC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
  } vec_t;

  typedef struct {
    logic        id;
    logic [15:0] res;
    logic [1:0]  err;
    int          lat;
    time         t_acc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  time  last_hs  = 0;
  logic prev_v   = 1'b0;
  vec_t v0[3];
  vec_t v1[3];

  // reference ALU; garbage on div-by-zero/illegal so passthrough would be caught
  always_comb begin
    bus.alu_result = 16'h0000;
    case (bus.alu_ctrl)
      OP_ADD: bus.alu_result = bus.alu_a + bus.alu_b;
      OP_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
      OP_AND: bus.alu_result = bus.alu_a & bus.alu_b;
      OP_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
      OP_XOR: bus.alu_result = bus.alu_a ^ bus.alu_b;
      OP_MUL: bus.alu_result = bus.alu_a * bus.alu_b;
      OP_DIV: bus.alu_result = (bus.alu_b != 16'h0) ? bus.alu_a / bus.alu_b : 16'hDEAD;
      OP_NOT: bus.alu_result = ~bus.alu_a;
      OP_MOD: bus.alu_result = (bus.alu_b != 16'h0) ? bus.alu_a % bus.alu_b : 16'hBEEF;
      OP_LDI: bus.alu_result = bus.alu_b;
      default: bus.alu_result = 16'h5A5A;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // samples 2 time units before each rising edge, well clear of both edges
  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_rsp: got id %0d result %0h, no response expected",
                   bus.rsp_id, bus.rsp_result);
        end else begin
          if (!prev_v)
            chk("latency", 64'((($time - 8) - q[0].t_acc) / 10), 64'(q[0].lat));
          chk("rsp_id", 64'(bus.rsp_id), 64'(q[0].id));
          chk("rsp_result", 64'(bus.rsp_result), 64'(q[0].res));
          chk("rsp_err", 64'(bus.rsp_err), 64'(q[0].err));
          chk("ready_in_resp", 64'({bus.req1_ready, bus.req0_ready}), 64'(0));
          if (bus.rsp_ready) begin
            last_hs = $time + 2;
            void'(q.pop_front());
          end
        end
      end
      prev_v = bus.rsp_valid;
    end
  end

  task automatic drive(input bit port, input bit v, input vec_t x);
    if (!port) begin
      bus.req0_valid = v; bus.req0_op = x.op; bus.req0_a = x.a; bus.req0_b = x.b;
    end else begin
      bus.req1_valid = v; bus.req1_op = x.op; bus.req1_a = x.a; bus.req1_b = x.b;
    end
  endtask

  // returns 1 time unit after the accepting edge
  task automatic issue(input bit port, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] res,
                       input logic [1:0] err, input int lat);
    vec_t x;
    bit   done;
    x    = '{op: op, a: a, b: b, res: res};
    done = 1'b0;
    @(negedge clk);
    drive(port, 1'b1, x);
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if ((!port && bus.req0_ready) || (port && bus.req1_ready)) begin
        @(posedge clk);
        q.push_back('{id: port, res: res, err: err, lat: lat, t_acc: $time});
        #1;
        drive(port, 1'b0, x);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: port %0d never saw ready, required within 60 cycles", port);
      drive(port, 1'b0, x);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(q.size()), 64'(0));
  endtask

  // both ports request every cycle; grants must alternate starting at port 0
  task automatic run_both();
    int   idx[2];
    bit   g;
    bit   p;
    int   n;
    vec_t x;
    idx[0] = 0; idx[1] = 0; g = 1'b0; n = 0;
    @(negedge clk);
    drive(1'b0, 1'b1, v0[0]);
    drive(1'b1, 1'b1, v1[0]);
    for (int k = 0; k < 100 && n < 6; k++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        p = bus.req1_ready;
        chk("grant_order", 64'(p), 64'(g));
        chk("single_grant", 64'(bus.req0_ready & bus.req1_ready), 64'(0));
        @(posedge clk);
        x = p ? v1[idx[p]] : v0[idx[p]];
        q.push_back('{id: p, res: x.res, err: 2'b00, lat: 1, t_acc: $time});
        idx[p]++;
        n++;
        g = ~g;
        #1;
        if (idx[p] < 3) drive(p, 1'b1, p ? v1[idx[p]] : v0[idx[p]]);
        else            drive(p, 1'b0, x);
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
    chk("both_count", 64'(n), 64'(6));
  endtask

  initial begin
    v0[0] = '{op: OP_ADD, a: 16'h1234, b: 16'h0001, res: 16'h1235};
    v0[1] = '{op: OP_AND, a: 16'hF0F0, b: 16'h0FF0, res: 16'h00F0};
    v0[2] = '{op: OP_XOR, a: 16'h00FF, b: 16'h0F0F, res: 16'h0FF0};
    v1[0] = '{op: OP_SUB, a: 16'h0010, b: 16'h0003, res: 16'h000D};
    v1[1] = '{op: OP_OR,  a: 16'h0F00, b: 16'h00F0, res: 16'h0FF0};
    v1[2] = '{op: OP_NOT, a: 16'h00FF, b: 16'h1111, res: 16'hFF00};

    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp_ready  = 1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result,
                              bus.alu_ctrl, bus.alu_a, bus.alu_b}), 64'(0));
    @(negedge clk);
    rst = 0;

    run_both();
    drain();

    issue(0, OP_ADD, 16'h1234, 16'h0001, 16'h1235, 2'b00, 1);
    issue(1, OP_ADD, 16'hFFFF, 16'h0002, 16'h0001, 2'b00, 1);
    issue(0, OP_LDI, 16'h0000, 16'hABCD, 16'hABCD, 2'b00, 1);
    issue(0, OP_MUL, 16'h1234, 16'h0010, 16'h2340, 2'b00, MC);
    drain();

    issue(1, OP_DIV, 16'h0064, 16'h0007, 16'h000E, 2'b00, MC);
    for (int i = 0; i < MC; i++) begin
      @(negedge clk);
      chk("alu_hold", 64'({bus.alu_ctrl, bus.alu_a, bus.alu_b}),
          64'({OP_DIV, 16'h0064, 16'h0007}));
    end
    drain();
    chk("alu_idle_hold", 64'({bus.alu_ctrl, bus.alu_a, bus.alu_b}),
        64'({OP_DIV, 16'h0064, 16'h0007}));

    issue(0, OP_MOD, 16'h0064, 16'h0007, 16'h0002, 2'b00, MC);
    issue(0, OP_DIV, 16'h0005, 16'h0000, 16'hFFFF, 2'b01, MC);
    issue(1, OP_MOD, 16'h0005, 16'h0000, 16'h0005, 2'b01, MC);
    issue(0, 4'b0110, 16'h0001, 16'h0002, 16'h0000, 2'b10, 1);
    issue(1, 4'b1111, 16'h00AA, 16'h0055, 16'h0000, 2'b10, 1);
    drain();

    // consumer stalls; a second request waits behind the held response
    bus.rsp_ready = 0;
    issue(0, OP_XOR, 16'h00FF, 16'hFFFF, 16'hFF00, 2'b00, 1);
    @(negedge clk);
    drive(1'b1, 1'b1, '{op: OP_SUB, a: 16'h0005, b: 16'h0001, res: 16'h0004});
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("stall_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'(0));
      @(negedge clk);
    end
    chk("stall_valid", 64'(bus.rsp_valid), 64'(1));
    #1;
    bus.rsp_ready = 1;
    issue(1, OP_SUB, 16'h0005, 16'h0001, 16'h0004, 2'b00, 1);
    chk("accept_after_hs", 64'(q[q.size()-1].t_acc - last_hs), 64'(10));
    drain();

    // reset asserted while a MUL sits in WAIT
    issue(0, OP_MUL, 16'h0003, 16'h0005, 16'h000F, 2'b00, MC);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1;
    #1;
    chk("async_reset_outputs", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_result,
                                    bus.alu_ctrl, bus.alu_a, bus.alu_b}), 64'(0));
    chk("async_reset_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'(0));
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < MC + 2; i++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", 64'(bus.rsp_valid), 64'(0));
    end

    run_both();
    drain();
    issue(0, OP_ADD, 16'h0100, 16'h0023, 16'h0123, 2'b00, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Two-port scheduler that shares the single combinational 16-bit ALU between two requesters (e.g. the instruction datapath and a debug/DMA port). It arbitrates round-robin, registers the operands and opcode that drive the ALU, and holds the ALU inputs stable for a programmable number of cycles on slow ops (MUL/DIV/MOD). It intercepts divide-by-zero and illegal opcodes, and returns one tagged response per request over a valid/ready channel.

## Interface
- `MC_CYCLES`, 4: total execute cycles for MUL/DIV/MOD; legal range 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-high.
- `req0_valid` / `req1_valid` in 1: request pending on port 0/1.
- `req0_ready` / `req1_ready` out 1: request accepted this cycle.
- `req0_op` / `req1_op` in 4: ALU opcode.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in 16 each: operands.
- `alu_a`, `alu_b` out 16: registered operands to the ALU.
- `alu_ctrl` out 4: registered opcode to the ALU.
- `alu_result` in 16: combinational ALU result.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out 1: port that issued the request.
- `rsp_result` out 16: result.
- `rsp_err` out 2: bit0 = divide-by-zero, bit1 = illegal opcode.

## Operation
- Opcodes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, MUL 0101, DIV 0111, NOT 1000, MOD 1001, LDI 1010. All others are illegal.
- Slow ops are MUL, DIV and MOD. All other legal ops are fast.
- The FSM has four states: IDLE, EXEC, WAIT, RESP.
- IDLE:
  - If either valid is high, the arbiter grants one port.
  - Only the granted port's ready is driven high, combinationally from valid.
  - On acceptance, latch op/a/b/id into the ALU-side registers and go to EXEC.
- Arbitration:
  - A last-grant pointer resets to 1, so port 0 wins the first contest.
  - On a tie, the port not granted last wins.
  - A sole requester always wins. The pointer updates only on acceptance.
- EXEC is always one cycle.
  - Fast op, or MC_CYCLES=1: capture the result at the end of EXEC and go to RESP.
  - Otherwise go to WAIT.
- WAIT: a 4-bit counter runs MC_CYCLES-1 cycles. Capture the result on the last cycle, then go to RESP.
- Divide-by-zero (DIV or MOD with B=0): `alu_result` is ignored.
  - DIV returns 16'hFFFF; MOD returns A.
  - `rsp_err[0]`=1. Full slow-op latency still applies.
- Illegal opcode: result 16'h0000, `rsp_err[1]`=1, fast latency.
- Arithmetic: results are truncated to 16 bits (MUL keeps the low half). DIV and MOD are unsigned.
- RESP: `rsp_valid` is held with a stable payload until `rsp_ready`. Then go to IDLE. No request is accepted while in RESP, so there is at most one op in flight.
- `alu_a`, `alu_b` and `alu_ctrl` hold their last value outside EXEC/WAIT, so there is no ALU input toggling.
- Reset, including mid-operation: state = IDLE, all outputs 0, pointer = 1, counter = 0. An in-flight response is discarded.

## Timing
- Request accepted at edge T:
  - Fast op: `rsp_valid` rises at cycle T+2.
  - Slow op: `rsp_valid` rises at cycle T+1+MC_CYCLES.
- The earliest next acceptance is in the cycle after the `rsp_valid`/`rsp_ready` handshake. With `rsp_ready` tied high, throughput is 1 op per 3 cycles (fast).
- ALU inputs are stable for MC_CYCLES full cycles on slow ops. This is the multicycle-path constraint for the divider.
- Requesters must not make valid depend on ready. Once asserted, valid and payload hold until ready.

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams;
  - the `ALU_W`=16 constant;
  - the FSM state encoding;
  - the `rsp_err` bit positions;
  - an `is_slow(op)` / `is_legal(op)` function pair.
- Sub-module `rr_arb2`: a 2-requester round-robin arbiter with a last-grant pointer, updated on an accept strobe.
- The ALU itself is instantiated outside this block.

## Test plan
- Port 0 ADD a=0x1234, b=0x0001, `rsp_ready`=1 → `rsp_valid` at T+2, result 0x1235, id 0, err 00.
- Both ports valid every cycle, all ops fast → grants alternate 0,1,0,1…, starting with 0 after reset. Each response's id matches its port.
- MC_CYCLES=4, DIV 0x0064/0x0007 → `alu_a`/`alu_b`/`alu_ctrl` stable 4 cycles; result 0x000E at T+5.
- DIV a=5, b=0 → result 0xFFFF, err 01. MOD a=5, b=0 → result 0x0005, err 01. Op 0110 → result 0x0000, err 10 at T+2.
- `rsp_ready` held low 6 cycles → payload stable and both req_ready low throughout; the next request is accepted only after the handshake.
- Assert `rst` during WAIT of a MUL → outputs 0 immediately (async), no response emitted. After release, a port-0 request is served normally.
